// File: rtl/aes_round_scheduler.sv
// Steps an AES key schedule round by round, offering each round key to the datapath.
// Latency: first round one cycle after start; stalls without bubbles on roundAck; aborts after TIMEOUT unacked cycles.
module aes_round_scheduler #(
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    keySize,
  input  logic [0:1919] keyExp,
  output logic [0:127]  roundKey,
  output logic [3:0]    roundIdx,
  output logic [1:0]    roundMode,
  output logic          roundValid,
  input  logic          roundAck,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [9:0] LP_TO_LAST = 10'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [0:1919] r_key;
  logic [3:0]    r_nr;
  logic [3:0]    r_idx, w_idx_nxt;
  logic [9:0]    r_cnt, w_cnt_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;
  logic          w_latch;
  logic [10:0]   w_base;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_idx_nxt   = 4'd0;
        w_cnt_nxt   = 10'd0;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        if (start) begin
          if (keySize != 2'b11) begin
            w_latch     = 1'b1;
            w_state_nxt = ST_RUN;
            w_valid_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // roundValid is always high in RUN, so roundAck alone means consumption
        if (roundAck) begin
          w_cnt_nxt = 10'd0;
          if (r_idx == r_nr) begin
            w_state_nxt = ST_FINISH;
            w_idx_nxt   = 4'd0;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end else if (r_cnt == LP_TO_LAST) begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = 4'd0;
          w_cnt_nxt   = 10'd0;
          w_valid_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 10'd1;
        end
      end
      ST_FINISH: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_key   <= '0;
      r_nr    <= 4'd0;
      r_idx   <= 4'd0;
      r_cnt   <= 10'd0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      if (w_latch) begin
        r_key <= keyExp;
        r_nr  <= {1'b0, keySize, 1'b0} + 4'd10;
      end
    end
  end

  assign w_base     = {r_idx, 7'd0};
  assign roundKey   = r_valid ? r_key[w_base +: 128] : '0;
  assign roundIdx   = r_idx;
  assign roundMode  = (r_idx == 4'd0) ? 2'b00 : ((r_idx == r_nr) ? 2'b10 : 2'b01);
  assign roundValid = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Scoreboard bench: each run's expected offers/done/err are queued by cycle from a per-round wait plan,
// and a negedge monitor pops and compares whatever the scheduler presents.
module tb_aes_round_scheduler;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst, start, roundAck;
  logic [1:0]    keySize;
  logic [0:1919] keyExp;
  logic [0:127]  roundKey;
  logic [3:0]    roundIdx;
  logic [1:0]    roundMode;
  logic          roundValid, busy, done, err;

  aes_round_scheduler #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .keySize(keySize), .keyExp(keyExp),
    .roundKey(roundKey), .roundIdx(roundIdx), .roundMode(roundMode),
    .roundValid(roundValid), .roundAck(roundAck), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = round offer, 1 = done pulse, 2 = err pulse, 3 = nothing presented
  typedef struct {
    int          kind;
    int          cyc;
    int          idx;
    logic [1:0]  mode;
    logic [0:127] key;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  int   waits[15];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [0:1919] rand_key();
    logic [0:1919] r;
    for (int i = 0; i < 60; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic void push(input int kind, input int c, input int idx,
                               input logic [1:0] mode, input logic [0:127] key);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.idx  = idx;
    e.mode = mode;
    e.key  = key;
    q.push_back(e);
  endfunction

  function automatic logic [1:0] mode_of(input int k, input int nr);
    if (k == 0) return 2'b00;
    if (k == nr) return 2'b10;
    return 2'b01;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      int   ak, ek;
      bit   has;
      exp_t e;
      ak  = roundValid ? 0 : (done ? 1 : (err ? 2 : 3));
      has = (q.size() > 0) && (q[0].cyc == cyc);
      ek  = has ? q[0].kind : 3;
      if (has || ak != 3) begin
        chk("event_kind", ak, ek);
        if (has) begin
          e = q.pop_front();
          case (e.kind)
            0: begin
              chk("round_idx", roundIdx, e.idx);
              chk("round_mode", roundMode, e.mode);
              chk("round_key", roundKey, e.key);
              chk("offer_flags_busy_done_err", {busy, done, err}, 3'b100);
            end
            1: chk("done_flags_valid_busy_err", {roundValid, busy, err}, 3'b000);
            default: begin
              chk("err_flags_valid_busy_done", {roundValid, busy, done}, 3'b000);
              chk("err_idle_ctl", {roundIdx, roundMode}, 6'd0);
            end
          endcase
        end
      end else begin
        chk("idle_key", roundKey, 128'd0);
        chk("idle_ctl_busy_idx_mode", {busy, roundIdx, roundMode}, 7'd0);
      end
    end
  end

  // One run: expected trace is derived from the start cycle, Nr and the per-round waits;
  // rst_k aborts with reset (plus start and ack) on the first offer cycle of round rst_k.
  task automatic run(input logic [1:0] ks, input int rst_k, input bit mid_start,
                     input bit fin_start, input bit idle_ack);
    int s, t, last, nr, rc, done_c, ms;
    bit ended;
    logic [0:1919] lk;
    bit ackp[int];
    bit stp[int];
    s = cyc; lk = rand_key(); rc = -1; done_c = -1; ended = 1'b0; last = s + 1;
    if (ks == 2'b11) begin
      push(2, s + 1, 0, 2'b00, '0);
    end else begin
      nr = 10 + 2 * int'(ks);
      t  = s + 1;
      for (int k = 0; k <= nr && !ended; k++) begin
        if (k == rst_k) begin
          push(0, t, k, mode_of(k, nr), lk[128*k +: 128]);
          ackp[t] = 1'b1; rc = t; last = t; ended = 1'b1;
        end else if (waits[k] >= TO) begin
          for (int j = 0; j < TO; j++) begin
            push(0, t + j, k, mode_of(k, nr), lk[128*k +: 128]);
            ackp[t + j] = 1'b0;
          end
          push(2, t + TO, 0, 2'b00, '0);
          last = t + TO; ended = 1'b1;
        end else begin
          for (int j = 0; j <= waits[k]; j++) begin
            push(0, t + j, k, mode_of(k, nr), lk[128*k +: 128]);
            ackp[t + j] = (j == waits[k]);
          end
          t = t + waits[k] + 1;
        end
      end
      if (!ended) begin
        push(1, t, 0, 2'b00, '0);
        done_c = t; last = t;
      end
      ms = s + 3;
      if (mid_start && ms < last && ms != rc) stp[ms] = 1'b1;
      if (fin_start && done_c >= 0) stp[done_c] = 1'b1;
    end
    for (int c = s; c <= last; c++) begin
      start    = (c == s) || stp.exists(c) || (c == rc);
      keySize  = (c == s) ? ks : 2'($urandom_range(0, 3));
      keyExp   = (c == s) ? lk : rand_key();
      roundAck = ackp.exists(c) ? ackp[c] : idle_ack;
      rst      = (c == rc);
      tick();
    end
    start = 1'b0; rst = 1'b0; roundAck = 1'b0;
  endtask

  initial begin
    int ks, rk;
    rst = 1'b1; start = 1'b0; roundAck = 1'b0; keySize = 2'b00; keyExp = '0;
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;

    for (int i = 0; i < 15; i++) waits[i] = 0;
    run(2'b00, -1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) waits[i] = 2;
    run(2'b10, -1, 1'b0, 1'b0, 1'b0);
    run(2'b11, -1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) waits[i] = 0;
    waits[0] = 100;
    run(2'b01, -1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) waits[i] = $urandom_range(0, 2);
    run(2'($urandom_range(0, 2)), 5, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) waits[i] = 1;
    run(2'b00, -1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) waits[i] = TO - 1;
    run(2'b01, -1, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      ks = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
      for (int i = 0; i < 15; i++)
        waits[i] = ($urandom_range(0, 49) == 0) ? $urandom_range(TO, TO + 3) : $urandom_range(0, TO - 1);
      rk = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 14) : -1;
      run(2'(ks), rk, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) tick();
    chk("queue_drained", q.size(), 0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
